pc_sequencer: RTL
=================

# pc_sequencer

Sequential owner of the program counter that drives the PC selection mux. It holds the PC register and runs the instruction-fetch handshake with instruction memory. It presents each fetched word to the control unit, then applies the control unit's next-PC decision using the mux select encoding: 0 = ALU result, 1 = concatenated jump target, 2 = increment, 3 = halt. It sits between the control unit, the ALU and instruction memory.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- INCR, 16'd2, increment added to PC for select 2.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- FetchReq  out  1  instruction-memory read request.
- FetchAddr  out  16  read address; always equals PC.
- FetchAck  in  1  memory returns InstrIn this cycle.
- InstrIn  in  16  instruction word from memory.
- Instr  out  16  latched instruction for the control unit.
- InstrValid  out  1  Instr is valid and awaiting a next-PC decision.
- NextValid  in  1  control unit presents a decision on NextSel.
- NextSel  in  2  0 = ALUPC, 1 = concatenated target, 2 = PC+INCR, 3 = halt.
- ALUPC  in  16  ALU-computed target.
- JumpImm  in  12  jump immediate.
- PC  out  16  current program counter.
- Halted  out  1  sequencer stopped in HALT.
- RetireCount  out  16  instructions retired; wraps modulo 2^16.

## Operation

- States: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset. Moves to FETCH unconditionally on the first CLK edge after Reset deasserts.
- FETCH: FetchReq=1, FetchAddr=PC, held stable until an edge where FetchAck=1.
  - On that edge: Instr <= InstrIn, state <= EXEC.
  - NextValid is ignored in FETCH.
- EXEC: FetchReq=0, InstrValid=1.
  - FetchAck is ignored in EXEC.
  - On an edge with NextValid=1 and NextSel 0–2: PC <= selected value, RetireCount <= RetireCount+1, state <= FETCH.
- NextSel 3 in EXEC with NextValid=1: PC unchanged, RetireCount+1, state <= HALT.
- HALT: Halted=1, FetchReq=0, InstrValid=0. Exit only via Reset.
- Selected value:
  - sel 0: ALUPC.
  - sel 1: {PC[15:13], JumpImm, 1'b0}.
  - sel 2: PC+INCR, truncated to 16 bits; 16'hFFFE+2 = 16'h0000.
- Reset (asynchronous, any state, including mid-fetch with FetchReq high), all outputs immediately:
  - state=IDLE, PC=RESET_PC, Instr=0, InstrValid=0, FetchReq=0, Halted=0, RetireCount=0.

## Timing

- All outputs are registered or decoded from registered state only; no combinational path from inputs to FetchReq, InstrValid or Halted.
- Reset release to FetchReq=1: 1 cycle.
- FetchAck edge to InstrValid=1: visible the cycle after the edge.
- NextValid edge to new FetchReq=1 with updated FetchAddr: visible the cycle after the edge.
- Minimum instruction period is 2 cycles (FetchAck present on the first FETCH cycle, NextValid present on the first EXEC cycle).
- Wait states are unbounded on both handshakes; outputs hold steady while waiting.
- RetireCount wraps 16'hFFFF -> 16'h0000 without any flag.

## Test plan

- Reset with RESET_PC=0, then release; FetchAck=1 first FETCH cycle, InstrIn=16'h1234 -> FetchReq at cycle 1 with FetchAddr=0; Instr=16'h1234, InstrValid=1 at cycle 2.
- EXEC with NextSel=2, PC=0 -> PC=2, FetchAddr=2, RetireCount=1. Repeat from PC=16'hFFFE -> PC=16'h0000.
- PC=16'hA000, NextSel=1, JumpImm=12'h07F -> PC=16'hA0FE. Then NextSel=0, ALUPC=25 -> PC=25.
- FetchAck held low 5 cycles -> FetchReq and FetchAddr stable throughout, InstrValid=0. NextValid pulsed during FETCH -> PC unchanged.
- NextSel=3 -> Halted=1, FetchReq=0 forever. FetchAck and NextValid pulses -> no change. Reset -> PC=RESET_PC, Halted=0.
- Assert Reset mid-FETCH, between clock edges -> FetchReq=0 and PC=RESET_PC before the next edge. RetireCount=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner: runs the instruction-fetch handshake with memory and
// applies the control unit's next-PC decision (0 ALU, 1 jump, 2 increment, 3 halt).
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] INCR     = 16'd2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        FetchReq,
  output logic [15:0] FetchAddr,
  input  logic        FetchAck,
  input  logic [15:0] InstrIn,
  output logic [15:0] Instr,
  output logic        InstrValid,
  input  logic        NextValid,
  input  logic [1:0]  NextSel,
  input  logic [15:0] ALUPC,
  input  logic [11:0] JumpImm,
  output logic [15:0] PC,
  output logic        Halted,
  output logic [15:0] RetireCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_retireCount;
  logic        r_fetchReq;
  logic        r_instrValid;
  logic        r_halted;

  logic [15:0] w_selPc;

  // Jump target keeps the top three PC bits and forces a halfword-aligned address.
  always_comb begin
    w_selPc = r_pc + INCR;
    case (NextSel)
      2'd0:    w_selPc = ALUPC;
      2'd1:    w_selPc = {r_pc[15:13], JumpImm, 1'b0};
      default: w_selPc = r_pc + INCR;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 16'h0000;
      r_retireCount <= 16'h0000;
      r_fetchReq    <= 1'b0;
      r_instrValid  <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_fetchReq <= 1'b1;
        end
        FETCH: begin
          if (FetchAck) begin
            r_state      <= EXEC;
            r_instr      <= InstrIn;
            r_fetchReq   <= 1'b0;
            r_instrValid <= 1'b1;
          end
        end
        EXEC: begin
          if (NextValid) begin
            r_retireCount <= r_retireCount + 16'd1;
            r_instrValid  <= 1'b0;
            if (NextSel == 2'd3) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_state    <= FETCH;
              r_pc       <= w_selPc;
              r_fetchReq <= 1'b1;
            end
          end
        end
        HALT: begin
          r_fetchReq   <= 1'b0;
          r_instrValid <= 1'b0;
          r_halted     <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign FetchReq    = r_fetchReq;
  assign FetchAddr   = r_pc;
  assign PC          = r_pc;
  assign Instr       = r_instr;
  assign InstrValid  = r_instrValid;
  assign Halted      = r_halted;
  assign RetireCount = r_retireCount;

endmodule
